ce_divider_multi: RTL and testbench

Parametrised multi-channel clock-enable generator. It derives N_CH independent single-cycle clock-enable strobes from the one system clock. Each channel has a runtime-programmable divide ratio and a periodic or one-shot mode. It feeds counters, 7-segment scan logic and debouncers that all run on CLK and qualify with a CE rather than using derived clocks.

---
 rtl/ce_divider_multi.sv | 164 ++++++++++++++++
 tb/tb_ce_divider_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ce_divider_multi.sv
`timescale 1ns/1ps
// ce_divider_multi
// Multi-channel clock-enable generator. Every channel produces a single-cycle
// CE strobe every div_eff = max(div, 1) enabled clock edges, either
// periodically or once (one-shot). All consumers stay on CLK and qualify with
// the strobe instead of using derived clocks.
//
// Parameters:
//   CLK_HZ      system clock frequency (documentation only)
//   N_CH        number of channels (1..16)
//   DIV_W       width of divide-ratio registers and counters
//   DEFAULT_DIV divide ratio of every channel after RST
//   SEL_W       width of DIV_SEL, 2^SEL_W >= N_CH
//
// Ports:
//   CLK       system clock, rising edge
//   RST       asynchronous active-high reset
//   EN        global count enable; low = counters hold, no strobes
//   CLR       synchronous restart of all channels (div/mode kept)
//   DIV_LD    one-cycle load strobe for DIV_VAL/MODE_VAL into channel DIV_SEL
//   DIV_SEL   target channel of a load; values >= N_CH are ignored
//   DIV_VAL   new divide ratio
//   MODE_VAL  new mode: 0 = periodic, 1 = one-shot
//   CE_OUT    per-channel single-cycle enable strobe (registered)
//   DONE      per-channel one-shot completed flag (registered)
module ce_divider_multi #(
    parameter int CLK_HZ      = 40_000_000,
    parameter int N_CH        = 4,
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 40_000_000,
    parameter int SEL_W       = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic             DIV_LD,
    input  logic [SEL_W-1:0] DIV_SEL,
    input  logic [DIV_W-1:0] DIV_VAL,
    input  logic             MODE_VAL,
    output logic [N_CH-1:0]  CE_OUT,
    output logic [N_CH-1:0]  DONE
);

    localparam logic [DIV_W-1:0] DIV_ZERO    = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE     = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(DEFAULT_DIV);
    localparam logic [SEL_W:0]   N_CH_EXT    = (SEL_W+1)'(N_CH);
    localparam logic [N_CH-1:0]  CH_ZERO     = {N_CH{1'b0}};
    localparam logic [N_CH-1:0]  CH_ONES     = {N_CH{1'b1}};

    // An illegal configuration never accepts a load, so a mis-sized
    // DIV_SEL cannot corrupt a channel that does not exist.
    localparam bit PARAMS_OK = (N_CH >= 1) && (N_CH <= 16) &&
                               ((1 << SEL_W) >= N_CH) && (CLK_HZ > 0);

    // Per-channel state
    logic [DIV_W-1:0] cnt_r      [N_CH];
    logic [DIV_W-1:0] div_r      [N_CH];
    logic [N_CH-1:0]  mode_r;
    logic [N_CH-1:0]  armed_r;
    logic [N_CH-1:0]  ce_r;
    logic [N_CH-1:0]  done_r;

    // Next-state values
    logic [DIV_W-1:0] cnt_nxt_s  [N_CH];
    logic [DIV_W-1:0] div_nxt_s  [N_CH];
    logic [DIV_W-1:0] term_s     [N_CH];
    logic [N_CH-1:0]  mode_nxt_s;
    logic [N_CH-1:0]  armed_nxt_s;
    logic [N_CH-1:0]  ce_nxt_s;
    logic [N_CH-1:0]  done_nxt_s;

    logic             ld_valid_s;
    logic [SEL_W:0]   sel_ext_s;

    // Load qualification: the select is widened by one bit so it can be
    // compared against N_CH even when N_CH == 2^SEL_W.
    always_comb begin
        sel_ext_s  = {1'b0, DIV_SEL};
        ld_valid_s = DIV_LD && PARAMS_OK && (sel_ext_s < N_CH_EXT);
    end

    // Terminal count per channel: ratios 0 and 1 both terminate at 0,
    // which yields a strobe on every enabled edge.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (div_r[i] > DIV_ONE) begin
                term_s[i] = div_r[i] - DIV_ONE;
            end else begin
                term_s[i] = DIV_ZERO;
            end
        end
    end

    // Channel next-state: CLR > load of this channel > counting > hold.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        div_nxt_s   = div_r;
        mode_nxt_s  = mode_r;
        armed_nxt_s = armed_r;
        ce_nxt_s    = CH_ZERO;
        done_nxt_s  = done_r;
        for (int i = 0; i < N_CH; i++) begin
            if (CLR) begin
                cnt_nxt_s[i]   = DIV_ZERO;
                armed_nxt_s[i] = 1'b1;
                done_nxt_s[i]  = 1'b0;
            end else if (ld_valid_s && (sel_ext_s == (SEL_W+1)'(i))) begin
                div_nxt_s[i]   = DIV_VAL;
                mode_nxt_s[i]  = MODE_VAL;
                cnt_nxt_s[i]   = DIV_ZERO;
                armed_nxt_s[i] = 1'b1;
                done_nxt_s[i]  = 1'b0;
            end else if (EN) begin
                if (armed_r[i]) begin
                    if (cnt_r[i] >= term_s[i]) begin
                        // '>=' also folds any out-of-range count back to 0.
                        cnt_nxt_s[i] = DIV_ZERO;
                        ce_nxt_s[i]  = 1'b1;
                        if (mode_r[i]) begin
                            armed_nxt_s[i] = 1'b0;
                            done_nxt_s[i]  = 1'b1;
                        end else begin
                            armed_nxt_s[i] = 1'b1;
                        end
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + DIV_ONE;
                    end
                end else begin
                    // Finished one-shot parks at zero until reloaded.
                    cnt_nxt_s[i] = DIV_ZERO;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= DIV_ZERO;
                div_r[i] <= DIV_DEFAULT;
            end
            mode_r  <= CH_ZERO;
            armed_r <= CH_ONES;
            ce_r    <= CH_ZERO;
            done_r  <= CH_ZERO;
        end else begin
            cnt_r   <= cnt_nxt_s;
            div_r   <= div_nxt_s;
            mode_r  <= mode_nxt_s;
            armed_r <= armed_nxt_s;
            ce_r    <= ce_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign CE_OUT = ce_r;
    assign DONE   = done_r;

endmodule

// File: tb/tb_ce_divider_multi.sv
`timescale 1ns/1ps
// Self-checking bench for ce_divider_multi: stimulus pushes the expected
// CE_OUT/DONE for every edge into a scoreboard queue; a monitor pops and
// compares on the falling edge.
module tb_ce_divider_multi;

    localparam int N_CH  = 4;
    localparam int DIV_W = 26;
    localparam int SEL_W = 3;
    localparam int DEF   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr;
    logic             div_ld;
    logic [SEL_W-1:0] div_sel;
    logic [DIV_W-1:0] div_val;
    logic             mode_val;
    logic [N_CH-1:0]  ce_out;
    logic [N_CH-1:0]  done;

    ce_divider_multi #(
        .CLK_HZ      (40_000_000),
        .N_CH        (N_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF),
        .SEL_W       (SEL_W)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .EN       (en),
        .CLR      (clr),
        .DIV_LD   (div_ld),
        .DIV_SEL  (div_sel),
        .DIV_VAL  (div_val),
        .MODE_VAL (mode_val),
        .CE_OUT   (ce_out),
        .DONE     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0] ce;
        logic [N_CH-1:0] dn;
        string           name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Expected behaviour, expressed as "edges since restart": a strobe
    // whenever that count is a multiple of the effective ratio.
    int              ph   [N_CH];
    int              d    [N_CH];
    bit              os   [N_CH];
    bit              act  [N_CH];
    logic [N_CH-1:0] mce;
    logic [N_CH-1:0] mdone;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            ph[i] = 0; d[i] = DEF; os[i] = 1'b0; act[i] = 1'b1;
        end
        mce   = '0;
        mdone = '0;
    endtask

    task automatic model_edge();
        mce = '0;
        if (rst) begin
            model_reset();
        end else if (clr) begin
            for (int i = 0; i < N_CH; i++) begin
                ph[i] = 0; act[i] = 1'b1; mdone[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (div_ld && (int'(div_sel) == i)) begin
                    d[i]     = (div_val <= 1) ? 1 : int'(div_val);
                    os[i]    = mode_val;
                    ph[i]    = 0;
                    act[i]   = 1'b1;
                    mdone[i] = 1'b0;
                end else if (en && act[i]) begin
                    ph[i] = ph[i] + 1;
                    if ((ph[i] % d[i]) == 0) begin
                        mce[i] = 1'b1;
                        if (os[i]) begin
                            act[i]   = 1'b0;
                            mdone[i] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic push_exp(input string name);
        exp_t e;
        e.ce   = mce;
        e.dn   = mdone;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // One clock edge: inputs were set beforehand; strobes drop afterwards.
    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        push_exp(name);
        #1;
        div_ld = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic steps(input int n, input string name);
        for (int k = 0; k < n; k++) step(name);
    endtask

    task automatic load(input int ch, input int val, input bit mode, input string name);
        div_ld   = 1'b1;
        div_sel  = SEL_W'(ch);
        div_val  = DIV_W'(val);
        mode_val = mode;
        step(name);
    endtask

    // Monitor: compares one scoreboard entry per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if ((ce_out !== e.ce) || (done !== e.dn)) begin
                n_err++;
                $display("FAIL %s @%0t: got ce=%b done=%b, expected ce=%b done=%b",
                         e.name, $time, ce_out, done, e.ce, e.dn);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; div_ld = 1'b0;
        div_sel = '0; div_val = '0; mode_val = 1'b0;
        model_reset();

        // Reset state, then default ratio 4 on every channel
        steps(2, "reset_state");
        rst = 1'b0;
        steps(12, "default_div4");

        // ch1 periodic at 3 while the others keep running at 4
        load(1, 3, 1'b0, "ld_ch1_div3");
        steps(10, "ch1_div3");

        // ch2 one-shot at 5, stays quiet afterwards, reload clears DONE
        load(2, 5, 1'b1, "ld_ch2_oneshot");
        steps(22, "ch2_oneshot");
        load(2, 5, 1'b0, "reload_ch2");
        steps(6, "ch2_periodic5");

        // Ratios 0 and 1 strobe every enabled cycle
        load(3, 0, 1'b0, "ld_ch3_div0");
        steps(4, "ch3_div0");
        load(3, 1, 1'b0, "ld_ch3_div1");
        steps(4, "ch3_div1");

        // EN dropped for 3 cycles at count 2 of a ratio-4 channel
        clr = 1'b1;
        step("clr_before_en");
        steps(2, "pre_en_gap");
        en = 1'b0;
        steps(3, "en_low");
        en = 1'b1;
        steps(8, "en_resume");

        // CLR mid-count restarts every channel
        steps(2, "pre_clr");
        clr = 1'b1;
        step("clr_mid");
        steps(8, "post_clr");

        // CLR and DIV_LD together: CLR wins and div is kept
        clr = 1'b1;
        load(0, 7, 1'b1, "clr_vs_ld");
        steps(8, "post_clr_vs_ld");

        // Out-of-range select is ignored
        load(N_CH, 2, 1'b1, "ld_sel_oob");
        steps(8, "post_sel_oob");

        // Load applies even with EN low
        en = 1'b0;
        load(0, 2, 1'b0, "ld_while_en_low");
        steps(2, "en_low_after_ld");
        en = 1'b1;
        steps(4, "ch0_div2");

        // Async reset between edges with DONE[2] high
        load(2, 2, 1'b1, "ld_ch2_os2");
        steps(3, "ch2_os2");
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b1;
        model_reset();
        push_exp("async_rst");
        #1;
        step("rst_hold");
        rst = 1'b0;
        steps(10, "post_rst_default");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
